// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared block-memory widths, footer layout and write-arbiter state type
package mem_pkg;

    localparam int ADDR_W       = 8;
    localparam int FOOTER_BITS  = 16;
    localparam int PAYLOAD_BITS = 48;
    localparam int BLOCK_BITS   = PAYLOAD_BITS + FOOTER_BITS;

    typedef struct packed {
        logic [7:0] seq;
        logic [7:0] crc8;
    } footer_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        CAPTURE,
        OUT
    } arb_state_t;

    // Footer occupies the low bits so the payload stays MSB-aligned in memory.
    function automatic logic [BLOCK_BITS-1:0] pack_block(
        input logic [PAYLOAD_BITS-1:0] payload,
        input footer_t                 footer
    );
        return {payload, footer};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after pointer, wrapping
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic                 valid,
    output logic [$clog2(N)-1:0] index
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Doubling the vector turns the wrap-around search into a plain slice.
    assign req_dbl = {req, req};
    assign rot     = req_dbl[pointer +: N];

    // Descending scan: the lowest rotated offset is assigned last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, pointer} + (IW+1)'(k);
                index = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            end
        end
    end

endmodule

// File: rtl/mem_write_arb.sv
// rtl/mem_write_arb.sv - round-robin arbiter funnelling NUM_PORTS block writers into one block memory
// Per-port accepted-write counters exist only with MEM_WRITE_ARB_STATS_EN defined.
module mem_write_arb
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            port_req_i,
    output logic [NUM_PORTS-1:0]            port_ready_o,
    input  logic [NUM_PORTS-1:0]            port_we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     port_addr_i,
    input  logic [NUM_PORTS*BLOCK_BITS-1:0] port_wdata_i,
    input  logic                            mem_ready_i,
    output logic                            mem_we_o,
    output logic [ADDR_W-1:0]               mem_addr_o,
    output logic [BLOCK_BITS-1:0]           mem_wdata_o,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_idx_o,
    output logic                            proto_err_o
`ifdef MEM_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         wr_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    arb_state_t            state;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  rr_valid;
    logic [IDX_W-1:0]      rr_idx;
    logic [NUM_PORTS-1:0]  win_onehot;
    logic [NUM_PORTS-1:0]  grant_onehot;
    logic [NUM_PORTS-1:0]  we_ok;
    logic [IDX_W-1:0]      next_ptr;
    logic [ADDR_W-1:0]     addr_arr  [NUM_PORTS];
    logic [BLOCK_BITS-1:0] wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g]  = port_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = port_wdata_i[g*BLOCK_BITS +: BLOCK_BITS];
    end

    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_rr (
        .req     (port_req_i),
        .pointer (rr_ptr),
        .valid   (rr_valid),
        .index   (rr_idx)
    );

    assign win_onehot   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << rr_idx;
    assign grant_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
    // Only the granted client's strobe during CAPTURE is legal; anything else is flagged.
    assign we_ok        = (state == CAPTURE) ? grant_onehot : '0;
    assign next_ptr     = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
    assign grant_idx_o  = grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            port_ready_o <= '0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            proto_err_o  <= 1'b0;
        end else begin
            port_ready_o <= '0;
            proto_err_o  <= |(port_we_i & ~we_ok);
            case (state)
                IDLE: begin
                    if (rr_valid) begin
                        grant_q      <= rr_idx;
                        port_ready_o <= win_onehot;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    rr_ptr <= next_ptr;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (port_we_i[grant_q]) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr_arr[grant_q];
                        mem_wdata_o <= wdata_arr[grant_q];
                        state       <= OUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (mem_ready_i) begin
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        // Chaining straight into GRANT is what keeps the 3-cycle write rate.
                        if (rr_valid) begin
                            grant_q      <= rr_idx;
                            port_ready_o <= win_onehot;
                            state        <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_WRITE_ARB_STATS_EN
    logic [15:0] wr_cnt [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_cnt[i] <= '0;
            end
        end else if (state == OUT && mem_ready_i && wr_cnt[grant_q] != 16'hFFFF) begin
            wr_cnt[grant_q] <= wr_cnt[grant_q] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign wr_cnt_o[g*16 +: 16] = wr_cnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_write_arb.sv
// tb/tb_mem_write_arb.sv - randomized scoreboard bench for mem_write_arb with directed corner cases
module tb_mem_write_arb;
    import mem_pkg::*;

    localparam int NP = 4;
    localparam int IW = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NP-1:0]            port_req = '0;
    logic [NP-1:0]            port_ready;
    logic [NP-1:0]            port_we = '0;
    logic [NP*ADDR_W-1:0]     port_addr = '0;
    logic [NP*BLOCK_BITS-1:0] port_wdata = '0;
    logic                     mem_ready = 1'b0;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [BLOCK_BITS-1:0]    mem_wdata;
    logic [IW-1:0]            grant_idx;
    logic                     proto_err;
`ifdef MEM_WRITE_ARB_STATS_EN
    logic [NP*16-1:0]         wr_cnt;
`endif

    always #5 clk = ~clk;

    mem_write_arb #(.NUM_PORTS(NP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port_req_i   (port_req),
        .port_ready_o (port_ready),
        .port_we_i    (port_we),
        .port_addr_i  (port_addr),
        .port_wdata_i (port_wdata),
        .mem_ready_i  (mem_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .grant_idx_o  (grant_idx),
        .proto_err_o  (proto_err)
`ifdef MEM_WRITE_ARB_STATS_EN
        ,
        .wr_cnt_o     (wr_cnt)
`endif
    );

    typedef struct packed {
        logic [IW-1:0]         port;
        logic [ADDR_W-1:0]     addr;
        logic [BLOCK_BITS-1:0] data;
    } wr_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    logic err_q[$];
    int   acc[NP];

    int            p_req = 0, p_wd = 0, p_rogue = 0, p_mrdy = 100;
    logic [NP-1:0] wd_force = '0;
    logic [NP-1:0] rogue_force = '0;
    logic [NP-1:0] ready_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic raise(input int p);
        footer_t f;
        f.seq  = 8'($urandom);
        f.crc8 = 8'($urandom);
        port_addr[p*ADDR_W +: ADDR_W]          = ADDR_W'($urandom);
        port_wdata[p*BLOCK_BITS +: BLOCK_BITS] = pack_block(PAYLOAD_BITS'({$urandom, $urandom}), f);
        port_req[p] = 1'b1;
    endtask

    // One client cycle: strobe one cycle after ready, drop req on ready, inject illegal strobes.
    task automatic step();
        logic [NP-1:0] rdy;
        logic          rogue;
        int            r;
        wr_t           e;
        rdy     = port_ready;
        rogue   = 1'b0;
        port_we = '0;
        for (int p = 0; p < NP; p++) begin
            if (ready_prev[p]) begin
                if (!wd_force[p] && $urandom_range(0, 99) >= p_wd) begin
                    port_we[p] = 1'b1;
                    e.port = IW'(p);
                    e.addr = port_addr[p*ADDR_W +: ADDR_W];
                    e.data = port_wdata[p*BLOCK_BITS +: BLOCK_BITS];
                    exp_q.push_back(e);
                end
                wd_force[p] = 1'b0;
            end
            if (rogue_force[p] && !ready_prev[p]) begin
                port_we[p] = 1'b1;
                rogue      = 1'b1;
            end
        end
        rogue_force = '0;
        r = $urandom_range(0, NP - 1);
        if ($urandom_range(0, 99) < p_rogue && !ready_prev[r]) begin
            port_we[r] = 1'b1;
            rogue      = 1'b1;
        end
        err_q.push_back(rogue);
        for (int p = 0; p < NP; p++) begin
            if (rdy[p]) port_req[p] = 1'b0;
            else if (!port_req[p] && !ready_prev[p] && $urandom_range(0, 99) < p_req) raise(p);
        end
        ready_prev = rdy;
        mem_ready  = ($urandom_range(0, 99) < p_mrdy);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        step();
    endtask

    task automatic wait_ready(input int p);
        int n;
        n = 0;
        while (n < 60 && !port_ready[p]) begin
            tick();
            n++;
        end
        check($sformatf("wait_ready_p%0d", p), port_ready[p], 1'b1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        port_req   = '0;
        port_we    = '0;
        ready_prev = '0;
        wd_force   = '0;
        rogue_force = '0;
        exp_q.delete();
        err_q.delete();
        repeat (2) @(negedge clk);
        check("rst_ready", port_ready, '0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_data", mem_wdata, '0);
        check("rst_grant_idx", grant_idx, '0);
        check("rst_proto_err", proto_err, 1'b0);
`ifdef MEM_WRITE_ARB_STATS_EN
        check("rst_wr_cnt", wr_cnt, '0);
`endif
        rst_n = 1'b1;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each accepted write.
    initial begin : monitor
        logic                  prev_we, prev_acc;
        logic [ADDR_W-1:0]     prev_addr;
        logic [BLOCK_BITS-1:0] prev_data;
        logic [NP-1:0]         prev_req;
        int                    wait_cnt[NP];
        wr_t                   e;
        logic                  eb;
        prev_we = 1'b0; prev_acc = 1'b0; prev_addr = '0; prev_data = '0; prev_req = '0;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        foreach (acc[i]) acc[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_we = 1'b0; prev_acc = 1'b0; prev_req = '0;
                foreach (wait_cnt[i]) wait_cnt[i] = 0;
                foreach (acc[i]) acc[i] = 0;
            end else begin
                check("ready_onehot0", ($countones(port_ready) <= 1), 1'b1);
                if (mem_we) begin
                    check("ready_during_out", port_ready, '0);
                end else begin
                    check("idle_addr_zero", mem_addr, '0);
                    check("idle_data_zero", mem_wdata, '0);
                end
                if (prev_we && !prev_acc) begin
                    check("stall_we", mem_we, 1'b1);
                    check("stall_addr", mem_addr, prev_addr);
                    check("stall_data", mem_wdata, prev_data);
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_port", grant_idx, e.port);
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                        acc[e.port]++;
                    end
                end
                if (err_q.size() > 1) begin
                    eb = err_q.pop_front();
                    check("proto_err", proto_err, eb);
                end
                for (int p = 0; p < NP; p++) begin
                    if (!prev_req[p]) wait_cnt[p] = 0;
                    else if (port_ready[p]) wait_cnt[p] = 0;
                    else if (|port_ready) begin
                        wait_cnt[p]++;
                        check($sformatf("rr_wait_p%0d", p), (wait_cnt[p] <= NP - 1), 1'b1);
                    end
                end
                prev_we   = mem_we;
                prev_acc  = mem_we && mem_ready;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
                prev_req  = port_req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int n;
        int gport[5];
        int gcyc[5];
        @(negedge clk);
        do_reset();

        // Single port, addr 0x05: ready at cycle 1, write at cycle 3, exactly once.
        tick();
        raise(0);
        port_addr[0 +: ADDR_W] = 8'h05;
        tick(); check("c29_ready_c1", port_ready, 4'b0001);
        tick(); check("c29_we_c2", mem_we, 1'b0);
        tick(); check("c29_we_c3", mem_we, 1'b1); check("c29_addr", mem_addr, 8'h05);
        n = 0;
        repeat (8) begin tick(); if (mem_we) n++; end
        check("c29_once", n, 0);

        // All ports continuously requesting: 0,1,2,3,0 at 3-cycle spacing.
        do_reset();
        p_req = 100;
        tick();
        n = 0;
        repeat (40) begin
            tick();
            if (|port_ready && n < 5) begin
                gport[n] = int'(grant_idx);
                gcyc[n]  = cyc;
                n++;
            end
        end
        check("c30_grants", n, 5);
        for (int i = 0; i < 5; i++) check($sformatf("c30_order_%0d", i), gport[i], i % NP);
        for (int i = 1; i < 5; i++) check($sformatf("c30_gap_%0d", i), gcyc[i] - gcyc[i-1], 3);
        p_req = 0;
        repeat (15) tick();

        // Memory stalled 10 cycles in OUT, waiting requester must not see ready.
        do_reset();
        p_mrdy = 0;
        tick();
        raise(1);
        raise(2);
        wait_ready(1);
        tick();
        tick(); check("c31_we_up", mem_we, 1'b1);
        repeat (10) begin
            tick();
            check("c31_hold_we", mem_we, 1'b1);
            check("c31_no_ready", port_ready, '0);
        end
        p_mrdy = 100;
        tick();
        tick(); check("c31_done_we", mem_we, 1'b0); check("c31_next_ready", port_ready, 4'b0100);
        repeat (8) tick();

        // Granted port 2 withdraws: no write, no error, next grant to port 3.
        do_reset();
        tick();
        raise(0); wait_ready(0); repeat (3) tick();
        raise(1); wait_ready(1); repeat (3) tick();
        wd_force[2] = 1'b1;
        raise(2);
        raise(3);
        wait_ready(2);
        tick();
        tick(); check("c32_no_we", mem_we, 1'b0); check("c32_no_err", proto_err, 1'b0);
        check("c32_idle_ready", port_ready, '0);
        tick(); check("c32_next_ready", port_ready, 4'b1000); check("c32_next_idx", grant_idx, 2'd3);
        repeat (6) tick();

        // Port 1 strobes while port 0 is granted.
        do_reset();
        tick();
        raise(0);
        wait_ready(0);
        rogue_force = 4'b0010;
        tick();
        tick(); check("c33_err", proto_err, 1'b1); check("c33_we", mem_we, 1'b1);
        check("c33_idx", grant_idx, 2'd0);
        tick(); check("c33_err_once", proto_err, 1'b0);
        repeat (4) tick();

        // Reset while a write is held in OUT.
        do_reset();
        p_mrdy = 0;
        tick();
        raise(0);
        wait_ready(0);
        tick();
        tick(); check("c34_we_before", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("c34_we_async", mem_we, 1'b0);
        check("c34_addr_async", mem_addr, '0);
        p_mrdy = 100;
        do_reset();
        n = 0;
        repeat (8) begin tick(); if (mem_we) n++; end
        check("c34_no_write", n, 0);
`ifdef MEM_WRITE_ARB_STATS_EN
        check("c34_wr_cnt", wr_cnt, '0);
`endif

        // Randomized traffic with withdrawals, illegal strobes and memory backpressure.
        do_reset();
        p_req = 30; p_wd = 10; p_rogue = 5; p_mrdy = 70;
        repeat (3000) tick();
        p_req = 0; p_rogue = 0; p_mrdy = 100;
        repeat (40) tick();
        check("drain_empty", exp_q.size(), 0);
`ifdef MEM_WRITE_ARB_STATS_EN
        for (int p = 0; p < NP; p++)
            check($sformatf("wr_cnt_p%0d", p), wr_cnt[p*16 +: 16], (acc[p] > 65535) ? 65535 : acc[p]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_arb.md
MEM_WRITE_ARB -- requirements
Module: mem_write_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, giving the number of write-controller clients (2..16).
REQ-002 SHALL use ADDR_W and BLOCK_BITS from mem_pkg for all address and data widths.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 port_req_i  input  NUM_PORTS  per-port request: client holds a completed block and wants the memory.
REQ-006 port_ready_o  output  NUM_PORTS  per-port memory-ready; at most one bit high per cycle.
REQ-007 port_we_i  input  NUM_PORTS  per-port write strobe, registered by the client.
REQ-008 port_addr_i  input  NUM_PORTS x ADDR_W  per-port block index.
REQ-009 port_wdata_i  input  NUM_PORTS x BLOCK_BITS  per-port block data (payload + footer).
REQ-010 mem_ready_i  input  1  block memory accepts a write this cycle.
REQ-011 mem_we_o / mem_addr_o / mem_wdata_o  output  1 / ADDR_W / BLOCK_BITS  registered write to block memory.
REQ-012 grant_idx_o  output  $clog2(NUM_PORTS)  index of current/last granted port.
REQ-013 proto_err_o  output  1  one-cycle pulse on client protocol violation.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, CAPTURE, OUT.
- IDLE: if any port_req_i bit is set, register the round-robin winner into grant_q and go to GRANT; else stay.
REQ-015 GRANT: SHALL drive port_ready_o = onehot(grant_q) for exactly one cycle, advance the RR pointer to grant_q+1 (mod NUM_PORTS), and go to CAPTURE.
REQ-016 CAPTURE: if port_we_i[grant_q]=1, SHALL load addr and data into the output registers, set mem_we_o next cycle, and go to OUT; else (client withdrew) SHALL write nothing, raise no error, and go to IDLE.
REQ-017 OUT: SHALL hold mem_we_o/addr/wdata stable until mem_ready_i=1. On acceptance, if any req is pending, SHALL select a winner and go directly to GRANT; else SHALL go to IDLE.
REQ-018 Round-robin: search starts at the RR pointer and wraps from NUM_PORTS-1 to 0. A requester SHALL wait at most NUM_PORTS-1 grants.
REQ-019 Latency with memory ready: req at cycle 0 (IDLE), port_ready_o at cycle 1, port_we_i at cycle 2, mem_we_o at cycle 3. Sustained rate SHALL be one write per 3 cycles.
REQ-020 A port_we_i bit set for a non-granted port, or in any state other than CAPTURE, SHALL be ignored and SHALL pulse proto_err_o on the following cycle. This does not alter the FSM.
REQ-021 mem_we_o SHALL be 0 in all states except OUT; addr and wdata SHALL be zero when mem_we_o=0.
REQ-022 A req deasserted during GRANT SHALL NOT cancel the ready pulse.

Reset
REQ-023 Reset SHALL set state=IDLE, RR pointer=0, grant_q=0, and all outputs to 0, including stats counters.
REQ-024 Reset mid-transaction SHALL discard any captured write; no mem_we_o pulse SHALL follow reset release without a new grant.

Configuration
REQ-025 With MEM_WRITE_ARB_STATS_EN defined:
- SHALL add output wr_cnt_o (NUM_PORTS x 16) with per-port saturating counts of writes accepted by memory (OUT with mem_ready_i=1).
- Counters saturate at 0xFFFF.
REQ-026 Without MEM_WRITE_ARB_STATS_EN, the port and counters SHALL NOT exist. Behaviour is otherwise identical.

Structure
REQ-027 The arbiter state enum (arb_state_t) SHALL be placed in mem_pkg, next to ADDR_W, BLOCK_BITS and footer_t.
REQ-028 The round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req and pointer; outputs valid and index), purely combinational.

Verification
REQ-029 Single port: req[0]=1 with mem_ready_i=1, port 0 writes addr 0x05 -> port_ready_o=0001 at cycle 1, mem_we_o=1 with mem_addr_o=0x05 at cycle 3, exactly once.
REQ-030 All four ports requesting continuously -> grant order 0,1,2,3,0; one mem_we_o every 3 cycles; each port's data lands at its own address.
REQ-031 mem_ready_i held low for 10 cycles in OUT -> mem_we_o/addr/wdata stable for 10 cycles; no port_ready_o asserted; write completes on the first ready cycle.
REQ-032 Granted port 2 gives no we in CAPTURE -> no mem_we_o, proto_err_o=0, FSM back in IDLE; the next grant goes to port 3 if requesting.
REQ-033 Port 1 asserts we while port 0 is granted -> proto_err_o pulses once; only port 0's data is written.
REQ-034 rst_n asserted during OUT -> mem_we_o=0 immediately; after release, no write until a new request; with stats enabled, wr_cnt_o=0.
